quad_velocity: RTL and testbench
================================

// Module: quad_velocity
// PURPOSE
//  Downstream of the quadrature decoder. Samples its 24-bit position count once per sample period
//  and produces a signed per-period velocity, a moving average of the last 2**AVG_LOG2 velocities,
//  and a stall flag. Results go to the motor control loop and to the SPI status registers.
// PARAMETERS
//  CLK_FREQ_HZ   32_000_000  system clock frequency
//  SAMPLE_HZ     1000        velocity sample rate; TICKS = CLK_FREQ_HZ/SAMPLE_HZ (32000 by default)
//  OUT_W         16          signed velocity output width
//  AVG_LOG2      2           moving-average depth = 2**AVG_LOG2 samples
//  STALL_WINDOWS 50          consecutive zero-delta periods before stalled asserts
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         asynchronous active-low reset
//  count         in   24        decoder position count (modular), sync to clk
//  clear         in   1         sync clear: restart measurement
//  velocity      out  OUT_W     signed counts/period, saturated
//  velocity_avg  out  OUT_W     signed moving average of velocity
//  vel_valid     out  1         1-cycle strobe: velocity and velocity_avg updated
//  stalled       out  1         level: no motion for STALL_WINDOWS periods
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, tick counter 0, ring buffer and sum 0, state PRIME.
//  - Tick counter runs 0..TICKS-1 and wraps. tick = (cnt == TICKS-1).
//  - FSM PRIME -> RUN: in PRIME, tick latches count_prev <= count, vel_valid stays 0, and the FSM
//    moves to RUN. In RUN, each tick computes delta = count - count_prev (24-bit modular, read as
//    two's complement) and updates count_prev <= count.
//  - Wrap-around is handled by the modular subtraction: 0xFFFFF0 -> 0x000010 gives +32.
//  - Saturation: if delta > 2**(OUT_W-1)-1, output the max positive value; if delta < -2**(OUT_W-1),
//    output the min negative value. The saturated value goes both to velocity and into the ring.
//  - Moving average:
//    - Ring of 2**AVG_LOG2 entries, OUT_W bits each, plus a write pointer.
//    - Running sum is OUT_W+AVG_LOG2 bits: sum_next = sum + new - oldest; oldest is overwritten.
//    - velocity_avg = sum_next >>> AVG_LOG2 (arithmetic shift, rounds toward -inf).
//    - The ring starts zeroed, so the average ramps up over the first 2**AVG_LOG2 samples.
//  - Latency: tick in RUN at cycle T -> velocity, velocity_avg, stalled registered and vel_valid=1
//    at T+1. vel_valid is low at all other times.
//  - Stall:
//    - A zero-run counter increments on each RUN tick with delta==0 and saturates at STALL_WINDOWS.
//    - Any nonzero delta clears it to 0.
//    - stalled = (zero-run counter == STALL_WINDOWS), updated with vel_valid.
//  - clear=1 (sync, 1 cycle):
//    - Resets the tick counter, ring, sum, zero-run counter and outputs to 0; the FSM goes to PRIME.
//    - clear overrides a tick in the same cycle: no vel_valid is produced.
//  - Reset mid-period: everything returns to reset values immediately; the first valid result is
//    2*TICKS cycles after release.
//  - count changing on the tick cycle: the value present on that cycle is the one sampled.
// STRUCTURE
//  - Shared package motor_pkg: COUNT_W=24 and function sat_signed(in, width).
//  - One sub-module, vel_avg_ring:
//    - Holds the ring buffer, write pointer and running sum.
//    - Ports: clk, rst_n, clear, push, din[OUT_W], avg[OUT_W].
//    - It is shared later by the current-sense filter.
//  - The top level holds the tick counter, PRIME/RUN FSM, delta/saturation and stall logic.
// TESTING  (bench overrides TICKS=100 via CLK_FREQ_HZ=100_000, SAMPLE_HZ=1000)
//  1. After reset, count += 37 per period: first strobe at 2*TICKS -> velocity=37; after 4 strobes
//     velocity_avg=37 (first strobes 9,18,27 from the ramp).
//  2. count = 0xFFFFF0 at one tick, 0x000010 at the next -> velocity=+32; the reverse -> -32.
//  3. delta of +40000 -> velocity=32767; delta of -40000 -> velocity=-32768; ring stores saturated.
//  4. count held constant -> stalled=1 on the 50th zero strobe; one step of +1 -> stalled=0 at the
//     next strobe.
//  5. clear asserted on the tick cycle -> no vel_valid that period; outputs 0; next strobe after
//     2*TICKS.
//  6. rst_n pulsed low mid-period -> outputs 0 asynchronously; recovery as in test 1;
//     vel_valid is never wider than 1 cycle.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared motor-control types and helpers: position count width, velocity FSM states,
// and a signed saturation helper used by the velocity and current-sense datapaths.
// No ports; pure package.
package motor_pkg;

  localparam int COUNT_W = 24;

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } vel_state_t;

  // Clamp a COUNT_W-bit signed value into the signed range of 'width' bits.
  // The result stays COUNT_W bits wide (sign-extended); callers truncate to 'width'.
  function automatic logic signed [COUNT_W-1:0] sat_signed(
    input logic signed [COUNT_W-1:0] v,
    input int                        width
  );
    logic signed [COUNT_W-1:0] hi;
    logic signed [COUNT_W-1:0] lo;
    hi = $signed({1'b0, {(COUNT_W-1){1'b1}}}) >>> (COUNT_W - width);
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/vel_avg_ring.sv
// Moving average over the last 2**AVG_LOG2 pushed samples via ring buffer + running sum.
// Latency: avg registered 1 cycle after push. Backpressure: none, push is accepted every cycle.
// Ports: clk, rst_n (async low), clear (sync), push, din[OUT_W] signed, avg[OUT_W] signed.
module vel_avg_ring
  import motor_pkg::*;
#(
  parameter int OUT_W    = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = OUT_W + AVG_LOG2;

  logic [OUT_W-1:0]        ring_q [DEPTH];
  logic [OUT_W-1:0]        ring_d [DEPTH];
  logic [AVG_LOG2-1:0]     wp_q, wp_d;
  logic signed [SUM_W-1:0] sum_q, sum_d, sum_next;
  logic [OUT_W-1:0]        avg_q, avg_d;

  always_comb begin
    ring_d = ring_q;
    wp_d   = wp_q;
    sum_d  = sum_q;
    avg_d  = avg_q;
    // Slot at wp_q holds the oldest sample; it is replaced by din.
    sum_next = sum_q + SUM_W'($signed(din)) - SUM_W'($signed(ring_q[wp_q]));
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) ring_d[i] = '0;
      wp_d  = '0;
      sum_d = '0;
      avg_d = '0;
    end else if (push) begin
      ring_d[wp_q] = din;
      wp_d         = wp_q + AVG_LOG2'(1);
      sum_d        = sum_next;
      // Arithmetic shift: floor division, rounds toward -inf.
      avg_d        = OUT_W'(sum_next >>> AVG_LOG2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wp_q  <= '0;
      sum_q <= '0;
      avg_q <= '0;
    end else begin
      ring_q <= ring_d;
      wp_q   <= wp_d;
      sum_q  <= sum_d;
      avg_q  <= avg_d;
    end
  end

  assign avg = avg_q;

endmodule

// File: rtl/quad_velocity.sv
// Samples the quadrature position once per period; outputs saturated velocity, its moving average, stall flag.
// Latency: sample tick at cycle T -> registered results with vel_valid strobe at T+1. Backpressure: none.
// Ports: clk, rst_n (async low), count[24], clear (sync) in; velocity, velocity_avg [OUT_W] signed, vel_valid, stalled out.
module quad_velocity
  import motor_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 32_000_000,
  parameter int SAMPLE_HZ     = 1000,
  parameter int OUT_W         = 16,
  parameter int AVG_LOG2      = 2,
  parameter int STALL_WINDOWS = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COUNT_W-1:0] count,
  input  logic               clear,
  output logic [OUT_W-1:0]   velocity,
  output logic [OUT_W-1:0]   velocity_avg,
  output logic               vel_valid,
  output logic               stalled
);

  localparam int TICKS  = CLK_FREQ_HZ / SAMPLE_HZ;
  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int ZR_W   = $clog2(STALL_WINDOWS + 1);

  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  vel_state_t         state_q, state_d;
  logic [COUNT_W-1:0] count_prev_q, count_prev_d;
  logic [OUT_W-1:0]   velocity_q, velocity_d;
  logic               vel_valid_q, vel_valid_d;
  logic               stalled_q, stalled_d;
  logic [ZR_W-1:0]    zero_run_q, zero_run_d;

  logic               tick;
  logic               push;
  logic [COUNT_W-1:0] delta;

  assign tick  = (tick_cnt_q == TICK_W'(TICKS - 1));
  // Modular subtraction makes decoder wrap-around come out as a small signed step.
  assign delta = count - count_prev_q;
  assign push  = tick && (state_q == ST_RUN) && !clear;

  always_comb begin
    tick_cnt_d   = tick ? '0 : tick_cnt_q + TICK_W'(1);
    state_d      = state_q;
    count_prev_d = count_prev_q;
    velocity_d   = velocity_q;
    vel_valid_d  = 1'b0;
    stalled_d    = stalled_q;
    zero_run_d   = zero_run_q;
    if (clear) begin
      tick_cnt_d = '0;
      state_d    = ST_PRIME;
      velocity_d = '0;
      stalled_d  = 1'b0;
      zero_run_d = '0;
    end else if (tick) begin
      count_prev_d = count;
      case (state_q)
        ST_PRIME: state_d = ST_RUN;
        ST_RUN: begin
          velocity_d  = OUT_W'(sat_signed($signed(delta), OUT_W));
          vel_valid_d = 1'b1;
          if (delta != '0)                               zero_run_d = '0;
          else if (zero_run_q != ZR_W'(STALL_WINDOWS))   zero_run_d = zero_run_q + ZR_W'(1);
          stalled_d   = (zero_run_d == ZR_W'(STALL_WINDOWS));
        end
        default: state_d = ST_PRIME;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q   <= '0;
      state_q      <= ST_PRIME;
      count_prev_q <= '0;
      velocity_q   <= '0;
      vel_valid_q  <= 1'b0;
      stalled_q    <= 1'b0;
      zero_run_q   <= '0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      count_prev_q <= count_prev_d;
      velocity_q   <= velocity_d;
      vel_valid_q  <= vel_valid_d;
      stalled_q    <= stalled_d;
      zero_run_q   <= zero_run_d;
    end
  end

  // The ring receives the same saturated value that goes out on velocity.
  vel_avg_ring #(
    .OUT_W   (OUT_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .push (push),
    .din  (OUT_W'(sat_signed($signed(delta), OUT_W))),
    .avg  (velocity_avg)
  );

  assign velocity  = velocity_q;
  assign vel_valid = vel_valid_q;
  assign stalled   = stalled_q;

endmodule

// File: tb/tb_quad_velocity.sv
module tb_quad_velocity;

  localparam int TICKS = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] count = '0;
  logic        clear = 1'b0;
  logic [15:0] velocity, velocity_avg;
  logic        vel_valid, stalled;

  quad_velocity #(
    .CLK_FREQ_HZ  (100_000),
    .SAMPLE_HZ    (1000),
    .OUT_W        (16),
    .AVG_LOG2     (2),
    .STALL_WINDOWS(50)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .count       (count),
    .clear       (clear),
    .velocity    (velocity),
    .velocity_avg(velocity_avg),
    .vel_valid   (vel_valid),
    .stalled     (stalled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] vel;
    logic [15:0] avg;
    logic        stl;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic vv_prev = 1'b0;

  // Reference model state
  logic [23:0] m_prev;
  bit          m_primed;
  int          m_ring[4];
  int          m_wp, m_sum, m_zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_primed = 0;
    for (int i = 0; i < 4; i++) m_ring[i] = 0;
    m_wp = 0;
    m_sum = 0;
    m_zero = 0;
  endtask

  // Drive count mid-period; the next tick lands 50 cycles later.
  task automatic period(input logic [23:0] c);
    logic [23:0] d;
    int di, sv;
    count = c;
    if (!m_primed) begin
      m_primed = 1;
    end else begin
      d  = c - m_prev;
      di = int'($signed(d));
      sv = (di > 32767) ? 32767 : (di < -32768) ? -32768 : di;
      m_sum = m_sum + sv - m_ring[m_wp];
      m_ring[m_wp] = sv;
      m_wp = (m_wp + 1) % 4;
      if (di == 0) begin
        if (m_zero < 50) m_zero++;
      end else begin
        m_zero = 0;
      end
      sb.push_back('{vel: 16'(sv), avg: 16'(m_sum >>> 2), stl: (m_zero == 50), cyc: cyc + 50});
    end
    m_prev = c;
    repeat (TICKS) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vel"}, 32'(velocity), 32'd0);
    chk({tag, "_avg"}, 32'(velocity_avg), 32'd0);
    chk({tag, "_valid"}, 32'(vel_valid), 32'd0);
    chk({tag, "_stalled"}, 32'(stalled), 32'd0);
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      vv_prev = 1'b0;
    end else begin
      if (vel_valid) begin
        exp_t e;
        chk("valid_width", 32'(vv_prev), 32'd0);
        chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          chk("velocity", 32'(velocity), 32'(e.vel));
          chk("velocity_avg", 32'(velocity_avg), 32'(e.avg));
          chk("stalled", 32'(stalled), 32'(e.stl));
        end
      end
      vv_prev = vel_valid;
    end
  end

  initial begin
    logic [23:0] c;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // 1: constant +37/period, ramping average 9,18,27,37
    c = 24'd100;
    period(c);
    for (int i = 0; i < 4; i++) begin
      c = c + 24'd37;
      period(c);
    end

    // 2: wrap-around in both directions
    period(24'hFFFFF0);
    period(24'h000010);
    period(24'hFFFFF0);
    c = 24'hFFFFF0;

    // 3: saturation both ways, then a zero step to expose ring contents
    c = c + 24'd40000;
    period(c);
    c = c - 24'd40000;
    period(c);
    period(c);

    // 4: stall after 50 zero strobes, released by a single +1 step
    for (int i = 0; i < 52; i++) period(c);
    chk("stall_level", 32'(stalled), 32'd1);
    c = c + 24'd1;
    period(c);
    chk("stall_release", 32'(stalled), 32'd0);

    // 5: clear on the tick cycle
    c = c + 24'd7;
    period(c);
    count = c + 24'd3;
    repeat (49) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    chk_zero("clear");
    repeat (50) @(negedge clk);
    c = c + 24'd3;
    period(c);
    c = c + 24'd11;
    period(c);

    // 6: asynchronous reset mid-period, then recovery like test 1
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (50) @(negedge clk);
    period(c);
    for (int i = 0; i < 4; i++) begin
      c = c + 24'd37;
      period(c);
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
